// File: rtl/mul_pipe_pkg.sv
// Shared constants, stage flag struct and partial-product shift helper for the
// pipelined block multiplier.
package mul_pipe_pkg;

    localparam int DEF_DATA_LENGTH  = 32;
    localparam int DEF_BLOCK_LENGTH = 16;
    localparam int DEF_TAG_WIDTH    = 4;

    localparam int NUM_BLOCKS = DEF_DATA_LENGTH / DEF_BLOCK_LENGTH;
    localparam int NUM_MULS   = NUM_BLOCKS * NUM_BLOCKS;
    localparam int LATENCY    = NUM_MULS + 2;

    typedef struct packed {
        logic valid;
        logic is_signed;
    } stage_flags_t;

    // Partial product j pairs a block j%nb with b block j/nb.
    function automatic int pp_shift(input int j, input int nb, input int bl);
        return bl * ((j % nb) + (j / nb));
    endfunction

endpackage

// File: rtl/mul_pipe_stream_mul_block.sv
// Unsigned W x W multiplier with a registered product that stalls with the pipe.
module mul_block #(
    parameter int W = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_o <= '0;
        end else if (en_i) begin
            p_o <= (2*W)'(a_i) * (2*W)'(b_i);
        end
    end

endmodule

// File: rtl/mul_pipe_stream.sv
// Fully pipelined N x N multiplier: one block partial product accumulated per
// stage, signed correction in the last stage, valid/ready with global stall.
module mul_pipe_stream
    import mul_pipe_pkg::*;
#(
    parameter  int DATA_LENGTH  = DEF_DATA_LENGTH,
    parameter  int BLOCK_LENGTH = DEF_BLOCK_LENGTH,
    parameter  int TAG_WIDTH    = DEF_TAG_WIDTH,
    localparam int N_BLOCKS     = DATA_LENGTH / BLOCK_LENGTH,
    localparam int N_MULS       = N_BLOCKS * N_BLOCKS,
    localparam int PIPE_LATENCY = N_MULS + 2,
    localparam int CNT_W        = $clog2(PIPE_LATENCY + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_LENGTH-1:0]   indata_a_i,
    input  logic [DATA_LENGTH-1:0]   indata_b_i,
    input  logic                     signed_i,
    input  logic [TAG_WIDTH-1:0]     tag_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [2*DATA_LENGTH-1:0] outdata_r_o,
    output logic [TAG_WIDTH-1:0]     tag_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         inflight_o
);

    localparam int PW = 2 * DATA_LENGTH;

    typedef struct packed {
        stage_flags_t           flags;
        logic [TAG_WIDTH-1:0]   tag;
        logic [DATA_LENGTH-1:0] a;
        logic [DATA_LENGTH-1:0] b;
        logic [PW-1:0]          sum;
    } stage_t;

    if (DATA_LENGTH % BLOCK_LENGTH != 0) begin : g_param_check
        $error("mul_pipe_stream: DATA_LENGTH must be a multiple of BLOCK_LENGTH");
    end

    stage_t                    stage_q [N_MULS+1];
    stage_t                    stage_d [N_MULS+1];
    logic [2*BLOCK_LENGTH-1:0] pp      [N_MULS];
    logic                      en;
    logic                      accept;
    logic [PW-1:0]             result_d;

    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;
    assign accept     = in_valid_i && en;

    // Multiplier j registers alongside stage j, so stage j+1 can add it.
    for (genvar j = 0; j < N_MULS; j++) begin : g_mul
        localparam int A_OFS = (j % N_BLOCKS) * BLOCK_LENGTH;
        localparam int B_OFS = (j / N_BLOCKS) * BLOCK_LENGTH;
        if (j == 0) begin : g_first
            mul_block #(.W(BLOCK_LENGTH)) u_mul (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (en),
                .a_i   (indata_a_i[A_OFS +: BLOCK_LENGTH]),
                .b_i   (indata_b_i[B_OFS +: BLOCK_LENGTH]),
                .p_o   (pp[j])
            );
        end else begin : g_rest
            mul_block #(.W(BLOCK_LENGTH)) u_mul (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (en),
                .a_i   (stage_q[j-1].a[A_OFS +: BLOCK_LENGTH]),
                .b_i   (stage_q[j-1].b[B_OFS +: BLOCK_LENGTH]),
                .p_o   (pp[j])
            );
        end
    end

    always_comb begin
        // NOTE: every combinationally written variable gets a full default
        // first, so no path through the block can infer a latch.
        stage_d[0]                 = '0;
        stage_d[0].flags.valid     = accept;
        stage_d[0].flags.is_signed = signed_i;
        stage_d[0].tag             = tag_i;
        stage_d[0].a               = indata_a_i;
        stage_d[0].b               = indata_b_i;
        for (int k = 1; k <= N_MULS; k++) begin
            stage_d[k]     = stage_q[k-1];
            stage_d[k].sum = stage_q[k-1].sum
                           + (PW'(pp[k-1]) << pp_shift(k - 1, N_BLOCKS, BLOCK_LENGTH));
        end
    end

    // Two's-complement correction of the unsigned product, modulo 2^PW.
    always_comb begin
        result_d = stage_q[N_MULS].sum;
        if (stage_q[N_MULS].flags.is_signed && stage_q[N_MULS].a[DATA_LENGTH-1]) begin
            result_d = result_d - {stage_q[N_MULS].b, {DATA_LENGTH{1'b0}}};
        end
        if (stage_q[N_MULS].flags.is_signed && stage_q[N_MULS].b[DATA_LENGTH-1]) begin
            result_d = result_d - {stage_q[N_MULS].a, {DATA_LENGTH{1'b0}}};
        end
    end

    // NOTE: only the valid bits need reset; the data fields are cleared too
    // because they share one struct register and it keeps the update uniform.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q     <= '{default: '0};
            out_valid_o <= 1'b0;
            outdata_r_o <= '0;
            tag_o       <= '0;
        end else if (en) begin
            stage_q     <= stage_d;
            out_valid_o <= stage_q[N_MULS].flags.valid;
            outdata_r_o <= result_d;
            tag_o       <= stage_q[N_MULS].tag;
        end
    end

    always_comb begin
        inflight_o = CNT_W'(out_valid_o);
        for (int k = 0; k <= N_MULS; k++) begin
            inflight_o = inflight_o + CNT_W'(stage_q[k].flags.valid);
        end
    end

    assign busy_o = (inflight_o != '0);

endmodule

// File: tb/tb_mul_pipe_stream.sv
// Self-checking bench for mul_pipe_stream: scoreboard of reference products,
// stall stability, latency, reset flush and a single-block configuration.
module tb_mul_pipe_stream;
    import mul_pipe_pkg::*;

    localparam int LAT   = LATENCY;
    localparam int CNT_W = $clog2(LAT + 1);

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rst_i;
    logic             in_valid_i, in_ready_o, signed_i;
    logic [31:0]      indata_a_i, indata_b_i;
    logic [3:0]       tag_i, tag_o;
    logic             out_valid_o, out_ready_i, busy_o;
    logic [63:0]      outdata_r_o;
    logic [CNT_W-1:0] inflight_o;

    logic        in_valid_16, in_ready_16, signed_16, out_valid_16, busy_16;
    logic [15:0] a_16, b_16;
    logic [3:0]  tag_in_16, tag_out_16;
    logic [31:0] r_16;
    logic [1:0]  inflight_16;

    mul_pipe_stream dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .indata_a_i  (indata_a_i),
        .indata_b_i  (indata_b_i),
        .signed_i    (signed_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .outdata_r_o (outdata_r_o),
        .tag_o       (tag_o),
        .busy_o      (busy_o),
        .inflight_o  (inflight_o)
    );

    mul_pipe_stream #(.DATA_LENGTH(16), .BLOCK_LENGTH(16), .TAG_WIDTH(4)) dut_d16 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_16),
        .in_ready_o  (in_ready_16),
        .indata_a_i  (a_16),
        .indata_b_i  (b_16),
        .signed_i    (signed_16),
        .tag_i       (tag_in_16),
        .out_valid_o (out_valid_16),
        .out_ready_i (1'b1),
        .outdata_r_o (r_16),
        .tag_o       (tag_out_16),
        .busy_o      (busy_16),
        .inflight_o  (inflight_16)
    );

    typedef struct {
        logic [63:0] r;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          chk_lat = 1'b0;
    bit          hold_pending = 1'b0;
    logic [63:0] snap_r;
    logic [3:0]  snap_tag;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // One clock cycle: inputs are already set; observe, score, then advance.
    task automatic step(output bit acc);
        exp_t e;
        #1;
        check("inflight", inflight_o, sb.size());
        check("inflight_max", int'(inflight_o) > LAT, 0);
        check("busy", busy_o, sb.size() != 0);
        check("in_ready", in_ready_o, !out_valid_o || out_ready_i);
        if (hold_pending) begin
            check("hold_valid", out_valid_o, 1);
            check("hold_data", outdata_r_o, snap_r);
            check("hold_tag", tag_o, snap_tag);
            hold_pending = 1'b0;
        end
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid_o, 0);
            end else begin
                e = sb.pop_front();
                check("data", outdata_r_o, e.r);
                check("tag", tag_o, e.tag);
                if (chk_lat) check("latency", cyc - e.cyc, LAT);
            end
        end
        acc = in_valid_i && in_ready_o;
        if (acc) begin
            e.r   = model(indata_a_i, indata_b_i, signed_i);
            e.tag = tag_i;
            e.cyc = cyc;
            sb.push_back(e);
        end
        if (out_valid_o && !out_ready_i) begin
            hold_pending = 1'b1;
            snap_r       = outdata_r_o;
            snap_tag     = tag_o;
        end
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        in_valid_i = 1'b1;
        indata_a_i = a;
        indata_b_i = b;
        signed_i   = s;
        tag_i      = t;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        in_valid_i = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic drain(input int max);
        bit acc;
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            step(acc);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        bit acc;
        int sent;
        int lat;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        indata_a_i  = '0;
        indata_b_i  = '0;
        signed_i    = 1'b0;
        tag_i       = '0;
        out_ready_i = 1'b1;
        in_valid_16 = 1'b0;
        a_16        = '0;
        b_16        = '0;
        signed_16   = 1'b0;
        tag_in_16   = '0;

        @(negedge clk_i);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_outdata", outdata_r_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_inflight", inflight_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_d16_valid", out_valid_16, 0);
        #2 rst_i = 1'b0;
        @(negedge clk_i);

        // Single beats with continuous ready: value, tag, exact latency, one-cycle pulse.
        chk_lat = 1'b1;
        send(32'd3, 32'd5, 1'b0, 4'hA);
        drain(20);
        check("single_pulse", out_valid_o, 0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1);
        drain(20);
        send(32'hFFFF_FFFF, 32'd2, 1'b1, 4'h2);
        drain(20);
        send(32'hFFFF_FFFF, 32'd2, 1'b0, 4'h3);
        drain(20);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 4'h4);
        send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'h5);
        drain(20);

        // Random stream under pseudo-random backpressure.
        chk_lat = 1'b0;
        sent    = 0;
        for (int n = 0; n < 600 && (sent < 20 || sb.size() != 0); n++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            if (sent < 20 && $urandom_range(0, 3) != 0) begin
                in_valid_i = 1'b1;
                indata_a_i = $urandom;
                indata_b_i = $urandom;
                signed_i   = 1'($urandom_range(0, 1));
                tag_i      = 4'(sent);
            end else begin
                in_valid_i = 1'b0;
            end
            step(acc);
            if (acc) sent++;
        end
        in_valid_i = 1'b0;
        check("stream_sent", sent, 20);
        check("stream_drain", sb.size(), 0);

        // Fill four operations with the head result stalled at the output, then reset.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            indata_a_i = $urandom;
            indata_b_i = $urandom;
            signed_i   = 1'b1;
            tag_i      = 4'(i + 8);
            step(acc);
        end
        in_valid_i = 1'b0;
        repeat (4) step(acc);
        check("pre_rst_inflight", inflight_o, 4);
        check("pre_rst_valid", out_valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_valid", out_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_inflight", inflight_o, 0);
        sb.delete();
        hold_pending = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(acc);
            check("post_rst_quiet", out_valid_o, 0);
        end
        chk_lat = 1'b1;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 4'hC);
        drain(20);

        // Single-block configuration: latency 3, signed 0x8000 * 0x8000.
        in_valid_16 = 1'b1;
        a_16        = 16'h8000;
        b_16        = 16'h8000;
        signed_16   = 1'b1;
        tag_in_16   = 4'h7;
        #1 check("d16_ready", in_ready_16, 1);
        @(negedge clk_i);
        in_valid_16 = 1'b0;
        lat = 1;
        while (!out_valid_16 && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        check("d16_latency", lat, 3);
        check("d16_data", r_16, 32'h4000_0000);
        check("d16_tag", tag_out_16, 4'h7);
        @(negedge clk_i);
        check("d16_pulse", out_valid_16, 0);
        check("d16_busy", busy_16, 0);
        check("d16_inflight", inflight_16, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
